// File: rtl/md_defs.sv
// Shared HI/LO multiply-divide encodings: opcodes, read selects and issue FSM states.
// These are the same constants the mult/div unit decodes.
package md_defs;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_MULT  = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_DIV   = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;

    localparam logic [1:0] MF_HI = 2'b01;
    localparam logic [1:0] MF_LO = 2'b10;

    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            MD_NONE, MD_MULTU, MD_MULT, MD_DIVU, MD_DIV, MD_MTHI, MD_MTLO: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_start(input logic [2:0] op);
        return (op == MD_MULTU) || (op == MD_MULT) || (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    // The illegal read code 11 keeps bit 1 set, so it resolves to the LO side.
    function automatic logic mf_sel_lo(input logic [1:0] mf);
        return (mf == MF_LO) || (mf == (MF_HI | MF_LO));
    endfunction

endpackage

// File: rtl/md_wdog.sv
// Latency watchdog for an in-flight mult/div: cycle counter, expected latency and
// a sticky error raised once the counter passes the expected latency plus slack.
module md_wdog
    import md_defs::*;
#(
    parameter int unsigned WDOG_SLK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] lat,
    output logic             cnt_zero,
    output logic             md_err
);

    localparam logic [CNT_W:0] SLK_EXT = (CNT_W + 1)'(WDOG_SLK);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic             err_q, err_d;
    logic [CNT_W:0]   limit;

    always_comb begin
        limit = {1'b0, exp_q} + SLK_EXT;
        cnt_d = cnt_q;
        exp_d = exp_q;
        err_d = err_q;
        if (load) begin
            cnt_d = '0;
            exp_d = lat;
        end else if (run && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (run && ({1'b0, cnt_q} > limit)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);
    assign md_err   = err_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue/hazard controller for the HI/LO mult/div unit.
// Optional feature: define MD_PERF_CNT_EN to add the perf_stall hazard-stall counter.
module md_issue_ctrl
    import md_defs::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned WDOG_SLK = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_md_op,
    input  logic [1:0]  e_mf,
    input  logic        d_md_use,
    input  logic        md_busy,
    input  logic        int_req,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic        md_flush,
    output logic        stall_d,
    output logic        hilo_sel,
    output logic        md_err,
`ifdef MD_PERF_CNT_EN
    output logic [31:0] perf_stall,
`endif
    output md_state_e   dbg_state
);

    localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] start_lat;
    logic             cnt_zero;
    logic             in_run;

    assign in_run = (state_q == ST_RUN);

    always_comb begin
        md_op     = (int_req || !op_is_legal(e_md_op)) ? MD_NONE : e_md_op;
        md_start  = !int_req && (state_q == ST_IDLE) && op_is_start(md_op);
        stall_d   = d_md_use && (md_start || in_run || md_busy);
        md_flush  = int_req && (in_run || md_busy);
        hilo_sel  = mf_sel_lo(e_mf);
        start_lat = op_is_div(md_op) ? DIV_LAT_C : MULT_LAT_C;
    end

    // md_busy is only meaningful from the second RUN cycle; cnt==0 masks a low busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (md_start) state_d = ST_RUN;
            ST_RUN:  if (md_flush || (!md_busy && !cnt_zero)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state = state_q;

    md_wdog #(
        .WDOG_SLK (WDOG_SLK)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .run      (in_run),
        .load     (md_start),
        .lat      (start_lat),
        .cnt_zero (cnt_zero),
        .md_err   (md_err)
    );

`ifdef MD_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q + {31'd0, stall_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall = perf_q;
`endif

endmodule
